// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART transmitter byte handshake bundle
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet round-robin arbiter feeding one UART tx byte port
// UART_ARB_TAG_EN prefixes every packet with a header byte 8'hA0 | grant_id.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int STALL_TIMEOUT = 255,
  parameter int CNT_W         = 8,
  localparam int GW           = $clog2(NUM_REQ)
) (
  input  logic              sysclk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus,
  output logic [GW-1:0]     grant_id,
  output logic              busy,
  output logic              timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1
`ifdef UART_ARB_TAG_EN
    , ST_TAG  = 2'd2
`endif
  } state_t;

`ifdef UART_ARB_TAG_EN
  localparam state_t FIRST_ST = ST_TAG;
`else
  localparam state_t FIRST_ST = ST_STREAM;
`endif

  localparam bit               TO_EN      = (STALL_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] STALL_LAST = TO_EN ? CNT_W'(STALL_TIMEOUT - 1) : '0;

  state_t           state_q, state_d;
  logic [GW-1:0]    last_grant_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [GW-1:0]    winner, cand;
  logic             found;
  logic             any_req, streaming, g_valid, g_last, xfer, stall, to_hit, pkt_end;
  logic [7:0]       g_data;

  assign any_req   = |bus.req_valid;
  assign streaming = (state_q == ST_STREAM);
  assign g_valid   = bus.req_valid[grant_id];
  assign g_last    = bus.req_last[grant_id];
  assign g_data    = bus.req_data[{grant_id, 3'b000} +: 8];
  assign xfer      = streaming && g_valid && bus.tx_ready;
  assign stall     = streaming && !g_valid;
  // the stall that would bring the count to STALL_TIMEOUT revokes the grant this cycle
  assign to_hit    = TO_EN && stall && (stall_cnt_q == STALL_LAST);
  assign pkt_end   = (xfer && g_last) || to_hit;

  // first requesting index after the last grant, wrapping modulo NUM_REQ
  always_comb begin
    winner = last_grant_q;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((int'(last_grant_q) + i) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_id     <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      stall_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && any_req) grant_id <= winner;
      if (pkt_end) last_grant_q <= grant_id;
      if (!streaming || xfer || to_hit) stall_cnt_q <= '0;
      else if (stall && TO_EN) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (any_req) state_d = FIRST_ST;
`ifdef UART_ARB_TAG_EN
      ST_TAG:    if (bus.tx_ready) state_d = ST_STREAM;
`endif
      ST_STREAM: if (pkt_end) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.tx_valid  = 1'b0;
    bus.tx_data   = 8'h00;
    bus.req_ready = '0;
    busy          = 1'b0;
    timeout_o     = 1'b0;
    case (state_q)
`ifdef UART_ARB_TAG_EN
      ST_TAG: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hA0 | 8'(grant_id);
        busy         = 1'b1;
      end
`endif
      ST_STREAM: begin
        bus.tx_valid            = g_valid;
        bus.tx_data             = g_data;
        bus.req_ready[grant_id] = bus.tx_ready;
        busy                    = 1'b1;
        timeout_o               = to_hit;
      end
      default: ;
    endcase
  end

endmodule
